// File: rtl/isa_pkg.sv
// Shared widths, MEM-stage FSM encoding and the MEM/WB bundle layout.
package isa_pkg;

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 24;
    localparam int unsigned REG_W  = 4;

    typedef enum logic {
        IDLE,
        WAIT
    } mem_state_t;

    typedef struct packed {
        logic [DATA_W-1:0] read_data;
        logic [ADDR_W-1:0] alu_out;
        logic [REG_W-1:0]  wa3;
        logic              valid;
        logic              pc_src;
        logic              reg_write;
        logic              mem_to_reg;
    } wb_t;

    // A bubble kills every side effect but keeps the data fields.
    function automatic wb_t wb_bubble(input wb_t prev);
        wb_t b;
        b            = prev;
        b.valid      = 1'b0;
        b.pc_src     = 1'b0;
        b.reg_write  = 1'b0;
        b.mem_to_reg = 1'b0;
        return b;
    endfunction

endpackage

// File: rtl/memwb_reg.sv
// MEM/WB pipeline register: loads a new bundle or turns itself into a bubble.
module memwb_reg
    import isa_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_load,
    input  wb_t  i_d,
    output wb_t  o_q
);

    wb_t r_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_q <= '0;
        end else if (i_load) begin
            r_q <= i_d;
        end else begin
            r_q <= wb_bubble(r_q);
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/mem_access_stage.sv
// Memory stage: req/ack handshake with data memory, upstream stall, timeout abort,
// and the MEM/WB register feeding writeback.
module mem_access_stage
    import isa_pkg::*;
#(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] A,
    input  logic [DATA_W-1:0] WD,
    input  logic [REG_W-1:0]  WA3M,
    input  logic              validM,
    input  logic              PCSrcM,
    input  logic              regWriteM,
    input  logic              memWriteM,
    input  logic              memToRegM,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              stallM,
    output logic [DATA_W-1:0] readDataW,
    output logic [ADDR_W-1:0] aluOutW,
    output logic [REG_W-1:0]  WA3W,
    output logic              validW,
    output logic              PCSrcW,
    output logic              regWriteW,
    output logic              memToRegW,
    output logic              memErr
);

    // Counter only needs to reach TIMEOUT-1: the abort fires in that WAIT cycle.
    localparam int unsigned    CntW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

    mem_state_t r_state;
    mem_state_t w_state_next;
    logic [CntW-1:0] r_cnt;
    logic [CntW-1:0] w_cnt_next;

    logic              r_mem_req;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              r_mem_err;

    logic w_mem_op;
    logic w_in_wait;
    logic w_timeout;
    logic w_start;
    logic w_ack;
    logic w_abort;

    wb_t  w_wb_in;
    wb_t  w_wb_d;
    wb_t  w_wb_q;
    logic w_wb_load;

    assign w_mem_op  = validM & (memToRegM | memWriteM);
    assign w_in_wait = (r_state == WAIT);
    assign w_timeout = w_in_wait & (r_cnt == CntLast);
    assign w_start   = (r_state == IDLE) & w_mem_op;
    assign w_ack     = w_in_wait & mem_ack;
    assign w_abort   = w_timeout & ~mem_ack;

    // Held low during reset so upstream never sees a stall from stale inputs.
    assign stallM = rst & (w_start | (w_in_wait & ~mem_ack & ~w_timeout));

    always_comb begin
        w_wb_in            = '0;
        w_wb_in.alu_out    = A;
        w_wb_in.wa3        = WA3M;
        w_wb_in.valid      = validM;
        w_wb_in.pc_src     = PCSrcM;
        w_wb_in.reg_write  = regWriteM;
        w_wb_in.mem_to_reg = memToRegM;
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_wb_load    = 1'b0;
        w_wb_d       = w_wb_in;

        unique case (r_state)
            IDLE: begin
                w_cnt_next = '0;
                if (w_mem_op) begin
                    w_state_next = WAIT;
                end else begin
                    w_wb_load = 1'b1;
                end
            end
            WAIT: begin
                w_cnt_next = r_cnt + 1'b1;
                if (mem_ack) begin
                    w_state_next     = IDLE;
                    w_wb_load        = 1'b1;
                    w_wb_d.valid     = 1'b1;
                    w_wb_d.read_data = memToRegM ? mem_rdata : '0;
                end else if (w_timeout) begin
                    // Aborted access still retires so the PC/control flow stays sane.
                    w_state_next     = IDLE;
                    w_wb_load        = 1'b1;
                    w_wb_d.valid     = 1'b1;
                    w_wb_d.reg_write = 1'b0;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else if (w_start) begin
            r_mem_req   <= 1'b1;
            r_mem_we    <= memWriteM;
            r_mem_addr  <= A;
            r_mem_wdata <= WD;
        end else if (w_ack | w_abort) begin
            r_mem_req <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mem_err <= 1'b0;
        end else if (w_abort) begin
            r_mem_err <= 1'b1;
        end
    end

    memwb_reg u_memwb_reg (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_wb_load),
        .i_d    (w_wb_d),
        .o_q    (w_wb_q)
    );

    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign memErr    = r_mem_err;

    assign readDataW = w_wb_q.read_data;
    assign aluOutW   = w_wb_q.alu_out;
    assign WA3W      = w_wb_q.wa3;
    assign validW    = w_wb_q.valid;
    assign PCSrcW    = w_wb_q.pc_src;
    assign regWriteW = w_wb_q.reg_write;
    assign memToRegW = w_wb_q.mem_to_reg;

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed table, corner sequences, random vs model.
module tb_mem_access_stage;

    localparam int unsigned TIMEOUT = 15;

    typedef struct {
        logic        v;
        logic        m2r;
        logic        mw;
        logic        rw;
        logic        pcs;
        logic [15:0] a;
        logic [23:0] wd;
        logic [3:0]  wa3;
    } instr_t;

    typedef struct {
        int          stall;
        logic        valid;
        logic        pcs;
        logic        rw;
        logic        m2r;
        logic [23:0] rd;
        logic [15:0] alu;
        logic [3:0]  wa3;
        logic        err;
    } res_t;

    typedef struct {
        instr_t      x;
        int          d;
        logic [23:0] rdata;
        res_t        e;
    } vec_t;

    logic        clk;
    logic        rst;
    logic [15:0] A;
    logic [23:0] WD;
    logic [3:0]  WA3M;
    logic        validM, PCSrcM, regWriteM, memWriteM, memToRegM;
    logic        mem_req, mem_we;
    logic [15:0] mem_addr;
    logic [23:0] mem_wdata;
    logic [23:0] mem_rdata;
    logic        mem_ack;
    logic        stallM;
    logic [23:0] readDataW;
    logic [15:0] aluOutW;
    logic [3:0]  WA3W;
    logic        validW, PCSrcW, regWriteW, memToRegW, memErr;

    int errors = 0;
    int checks = 0;

    mem_access_stage #(.TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .rst       (rst),
        .A         (A),
        .WD        (WD),
        .WA3M      (WA3M),
        .validM    (validM),
        .PCSrcM    (PCSrcM),
        .regWriteM (regWriteM),
        .memWriteM (memWriteM),
        .memToRegM (memToRegM),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .stallM    (stallM),
        .readDataW (readDataW),
        .aluOutW   (aluOutW),
        .WA3W      (WA3W),
        .validW    (validW),
        .PCSrcW    (PCSrcW),
        .regWriteW (regWriteW),
        .memToRegW (memToRegW),
        .memErr    (memErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic instr_t mk_i(input logic v, input logic m2r, input logic mw,
                                    input logic rw, input logic pcs, input logic [15:0] a,
                                    input logic [23:0] wd, input logic [3:0] wa3);
        instr_t x;
        x.v = v; x.m2r = m2r; x.mw = mw; x.rw = rw; x.pcs = pcs;
        x.a = a; x.wd = wd; x.wa3 = wa3;
        return x;
    endfunction

    function automatic res_t mk_e(input int stall, input logic valid, input logic pcs,
                                  input logic rw, input logic m2r, input logic [23:0] rd,
                                  input logic [15:0] alu, input logic [3:0] wa3,
                                  input logic err);
        res_t e;
        e.stall = stall; e.valid = valid; e.pcs = pcs; e.rw = rw; e.m2r = m2r;
        e.rd = rd; e.alu = alu; e.wa3 = wa3; e.err = err;
        return e;
    endfunction

    // Per-instruction outcome: d = WAIT cycles that pass before the ack cycle.
    function automatic res_t model(input instr_t x, input int d, input logic [23:0] rdata,
                                   input logic err_in);
        res_t e;
        e.alu = x.a; e.wa3 = x.wa3; e.pcs = x.pcs; e.m2r = x.m2r; e.err = err_in;
        if (!(x.v && (x.m2r || x.mw))) begin
            e.stall = 0; e.valid = x.v; e.rw = x.rw; e.rd = '0;
        end else if (d < int'(TIMEOUT)) begin
            e.stall = 1 + d; e.valid = 1'b1; e.rw = x.rw; e.rd = x.m2r ? rdata : 24'h0;
        end else begin
            e.stall = TIMEOUT; e.valid = 1'b1; e.rw = 1'b0; e.rd = '0; e.err = 1'b1;
        end
        return e;
    endfunction

    task automatic drive(input instr_t x);
        validM = x.v; memToRegM = x.m2r; memWriteM = x.mw; regWriteM = x.rw;
        PCSrcM = x.pcs; A = x.a; WD = x.wd; WA3M = x.wa3;
    endtask

    // Entered and left at posedge+1; memory side acks in WAIT cycle d+1.
    task automatic run_instr(input string tag, input instr_t x, input int d,
                             input logic [23:0] rdata, output res_t o);
        int  n;
        bit  done;
        bit  mop;
        mop = x.v && (x.m2r || x.mw);
        drive(x);
        mem_ack = 1'b0;
        mem_rdata = 24'($urandom);
        o.stall = 0;
        n = 0;
        done = 0;
        while (!done && n <= int'(TIMEOUT) + 4) begin
            if (n > 0) begin
                mem_ack = (n == d + 1);
                mem_rdata = (n == d + 1) ? rdata : 24'($urandom);
            end
            #1;
            if (mop && n == 1) begin
                chk({tag, ".mem_req"}, 32'(mem_req), 32'd1);
                chk({tag, ".mem_addr"}, 32'(mem_addr), 32'(x.a));
                chk({tag, ".mem_we"}, 32'(mem_we), 32'(x.mw));
                if (x.mw) chk({tag, ".mem_wdata"}, 32'(mem_wdata), 32'(x.wd));
                chk({tag, ".bubble_validW"}, 32'(validW), 32'd0);
            end
            if (stallM) o.stall++;
            else done = 1;
            @(posedge clk);
            #1;
            mem_ack = 1'b0;
            n++;
        end
        if (!done) chk({tag, ".stall_bound"}, 32'd0, 32'd1);
        if (mop) chk({tag, ".req_drop"}, 32'(mem_req), 32'd0);
        o.valid = validW; o.pcs = PCSrcW; o.rw = regWriteW; o.m2r = memToRegW;
        o.rd = readDataW; o.alu = aluOutW; o.wa3 = WA3W; o.err = memErr;
    endtask

    task automatic cmp(input string tag, input res_t o, input res_t e);
        chk({tag, ".stall"}, 32'(o.stall), 32'(e.stall));
        chk({tag, ".validW"}, 32'(o.valid), 32'(e.valid));
        chk({tag, ".PCSrcW"}, 32'(o.pcs), 32'(e.pcs));
        chk({tag, ".regWriteW"}, 32'(o.rw), 32'(e.rw));
        chk({tag, ".memToRegW"}, 32'(o.m2r), 32'(e.m2r));
        chk({tag, ".readDataW"}, 32'(o.rd), 32'(e.rd));
        chk({tag, ".aluOutW"}, 32'(o.alu), 32'(e.alu));
        chk({tag, ".WA3W"}, 32'(o.wa3), 32'(e.wa3));
        chk({tag, ".memErr"}, 32'(o.err), 32'(e.err));
    endtask

    initial begin
        vec_t   vecs[8];
        res_t   o;
        res_t   e;
        instr_t x;
        logic   err_m;
        int     d;
        logic [23:0] rd;

        vecs[0] = '{mk_i(1, 0, 0, 1, 0, 16'h1234, 24'h0, 4'd5), 0, 24'h0,
                    mk_e(0, 1, 0, 1, 0, 24'h0, 16'h1234, 4'd5, 0)};
        vecs[1] = '{mk_i(1, 1, 0, 1, 0, 16'h0040, 24'h0, 4'd2), 3, 24'hABCDEF,
                    mk_e(4, 1, 0, 1, 1, 24'hABCDEF, 16'h0040, 4'd2, 0)};
        vecs[2] = '{mk_i(1, 0, 1, 0, 0, 16'h0100, 24'h00FF00, 4'd0), 0, 24'h123456,
                    mk_e(1, 1, 0, 0, 0, 24'h0, 16'h0100, 4'd0, 0)};
        vecs[3] = '{mk_i(0, 1, 1, 0, 0, 16'h0200, 24'h111111, 4'd7), 0, 24'h0,
                    mk_e(0, 0, 0, 0, 1, 24'h0, 16'h0200, 4'd7, 0)};
        vecs[4] = '{mk_i(1, 0, 0, 0, 1, 16'h0300, 24'h0, 4'd0), 0, 24'h0,
                    mk_e(0, 1, 1, 0, 0, 24'h0, 16'h0300, 4'd0, 0)};
        vecs[5] = '{mk_i(1, 1, 0, 1, 0, 16'h0404, 24'h0, 4'd9), 14, 24'h5A5A5A,
                    mk_e(15, 1, 0, 1, 1, 24'h5A5A5A, 16'h0404, 4'd9, 0)};
        vecs[6] = '{mk_i(1, 1, 1, 1, 0, 16'h0505, 24'hC0FFEE, 4'd3), 1, 24'h0F0F0F,
                    mk_e(2, 1, 0, 1, 1, 24'h0F0F0F, 16'h0505, 4'd3, 0)};
        vecs[7] = '{mk_i(1, 1, 0, 1, 1, 16'h0606, 24'h0, 4'd4), 20, 24'h777777,
                    mk_e(15, 1, 1, 0, 1, 24'h0, 16'h0606, 4'd4, 1)};

        // Reset with a pending memory op on the inputs.
        rst = 1'b0;
        drive(mk_i(1, 1, 1, 1, 1, 16'($urandom), 24'($urandom), 4'($urandom)));
        mem_ack = 1'b1;
        mem_rdata = 24'($urandom);
        repeat (3) @(posedge clk);
        #2;
        chk("rst.mem_req", 32'(mem_req), 32'd0);
        chk("rst.mem_addr", 32'(mem_addr), 32'd0);
        chk("rst.mem_wdata", 32'(mem_wdata), 32'd0);
        chk("rst.mem_we", 32'(mem_we), 32'd0);
        chk("rst.stallM", 32'(stallM), 32'd0);
        chk("rst.wb", {8'(readDataW), 8'(aluOutW), 4'(WA3W), validW, PCSrcW, regWriteW,
                       memToRegW, memErr, 7'd0}, 32'd0);
        mem_ack = 1'b0;
        drive(mk_i(0, 0, 0, 0, 0, 16'h0, 24'h0, 4'd0));
        #3 rst = 1'b1;
        tick();

        foreach (vecs[i]) begin
            run_instr($sformatf("vec%0d", i), vecs[i].x, vecs[i].d, vecs[i].rdata, o);
            cmp($sformatf("vec%0d", i), o, vecs[i].e);
        end

        // After the timeout, an ack arriving in IDLE must be ignored.
        drive(mk_i(0, 0, 0, 0, 0, 16'h0, 24'h0, 4'd0));
        mem_ack = 1'b1;
        #1;
        chk("late_ack.stallM", 32'(stallM), 32'd0);
        tick();
        mem_ack = 1'b0;
        chk("late_ack.mem_req", 32'(mem_req), 32'd0);
        chk("late_ack.validW", 32'(validW), 32'd0);
        chk("late_ack.memErr", 32'(memErr), 32'd1);

        // Reset in the 2nd WAIT cycle aborts the access at once.
        drive(mk_i(1, 1, 0, 1, 0, 16'h0808, 24'h0, 4'd6));
        tick();
        tick();
        chk("midrst.req_before", 32'(mem_req), 32'd1);
        #1 rst = 1'b0;
        #1;
        chk("midrst.mem_req", 32'(mem_req), 32'd0);
        chk("midrst.stallM", 32'(stallM), 32'd0);
        chk("midrst.validW", 32'(validW), 32'd0);
        chk("midrst.memErr", 32'(memErr), 32'd0);
        drive(mk_i(0, 0, 0, 0, 0, 16'h0, 24'h0, 4'd0));
        #1 rst = 1'b1;
        tick();
        chk("midrst.no_wb", 32'(validW), 32'd0);
        x = mk_i(1, 0, 0, 1, 0, 16'h4321, 24'h0, 4'd11);
        run_instr("post_rst", x, 0, 24'h0, o);
        cmp("post_rst", o, mk_e(0, 1, 0, 1, 0, 24'h0, 16'h4321, 4'd11, 0));

        // Random instruction stream against the per-instruction model.
        err_m = 1'b0;
        for (int k = 0; k < 40; k++) begin
            x = mk_i(($urandom_range(0, 7) != 0), 1'($urandom), 1'($urandom), 1'($urandom),
                     1'($urandom), 16'($urandom), 24'($urandom), 4'($urandom));
            if ($urandom_range(0, 9) == 0) d = $urandom_range(TIMEOUT - 1, TIMEOUT + 2);
            else d = $urandom_range(0, 3);
            rd = 24'($urandom);
            e = model(x, d, rd, err_m);
            run_instr($sformatf("rnd%0d", k), x, d, rd, o);
            cmp($sformatf("rnd%0d", k), o, e);
            err_m = e.err;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
